// File: rtl/vx_cache_flush_pkg.sv
// vx_cache_flush_pkg: shared state encoding and geometry helpers for the flush sequencer.
package vx_cache_flush_pkg;
  typedef enum logic [2:0] {INIT, IDLE, FLUSH, DRAIN, DONE} state_e;
  function automatic int lines_f(int cache_size, int line_size, int num_banks, int num_ways);
    return cache_size / (line_size * num_banks * num_ways);
  endfunction
  function automatic int lsel_w_f(int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction
  function automatic int cnt_w_f(int max_pending);
    return $clog2(max_pending) + 1;
  endfunction
endpackage

// File: rtl/vx_cache_flush_if.sv
// vx_cache_flush_if: flush request/response handshakes plus the tag-stage op channel.
interface vx_cache_flush_if #(parameter int LSEL_W = 1, parameter int NUM_WAYS = 1);
  logic                flush_req_valid, flush_req_ready;
  logic                flush_rsp_valid, flush_rsp_ready;
  logic                op_valid, op_ready, op_init, op_flush;
  logic [LSEL_W-1:0]   op_line_sel;
  logic [NUM_WAYS-1:0] op_way_sel;
  logic                op_retire, op_evict, wb_ack;
  modport master (
    input  flush_req_valid, flush_rsp_ready, op_ready, op_retire, op_evict, wb_ack,
    output flush_req_ready, flush_rsp_valid, op_valid, op_init, op_flush, op_line_sel, op_way_sel
  );
  modport slave (
    output flush_req_valid, flush_rsp_ready, op_ready, op_retire, op_evict, wb_ack,
    input  flush_req_ready, flush_rsp_valid, op_valid, op_init, op_flush, op_line_sel, op_way_sel
  );
endinterface

// File: rtl/vx_flush_walker.sv
// vx_flush_walker: line-major, way-minor iterator; single collapses the way loop for init walks.
module vx_flush_walker #(
  parameter int LINES    = 4,
  parameter int NUM_WAYS = 1,
  parameter int LSEL_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                advance,
  input  logic                single,
  output logic [LSEL_W-1:0]   line_cnt,
  output logic [NUM_WAYS-1:0] way_oh,
  output logic                last
);
  logic wrap;
  assign wrap = single || way_oh[NUM_WAYS-1];
  assign last = wrap && (line_cnt == LSEL_W'(LINES - 1));
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      line_cnt <= '0;
      way_oh   <= NUM_WAYS'(1);
    end else if (advance) begin
      line_cnt <= wrap ? (last ? '0 : line_cnt + LSEL_W'(1)) : line_cnt;
      way_oh   <= wrap ? NUM_WAYS'(1) : way_oh << 1;
    end
  end
endmodule

// File: rtl/vx_cache_flush_ctrl.sv
// vx_cache_flush_ctrl: per-bank init/flush sequencer for the tag store, throttled by outstanding writebacks.
// Optional VX_CACHE_FLUSH_PERF_EN adds perf_flush_cnt / perf_dirty_cnt outputs.
module vx_cache_flush_ctrl
  import vx_cache_flush_pkg::*;
#(
  parameter int CACHE_SIZE  = 1024,
  parameter int LINE_SIZE   = 16,
  parameter int NUM_BANKS   = 1,
  parameter int NUM_WAYS    = 1,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  vx_cache_flush_if.master  bus,
  output logic              init_busy,
  output logic              busy
`ifdef VX_CACHE_FLUSH_PERF_EN
  ,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_dirty_cnt
`endif
);
  localparam int LINES  = lines_f(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS);
  localparam int LSEL_W = lsel_w_f(LINES);
  localparam int CNT_W  = cnt_w_f(MAX_PENDING);
  state_e              state, state_n;
  logic [CNT_W-1:0]    inflight, pending_wb;
  logic [CNT_W:0]      occupancy;
  logic [LSEL_W-1:0]   line_cnt;
  logic [NUM_WAYS-1:0] way_oh;
  logic                last, issue, init_acc, ret, ret_ok, evict, ack_ok;
  assign occupancy = {1'b0, inflight} + {1'b0, pending_wb};
  assign issue     = bus.op_valid && bus.op_ready && state == FLUSH;
  assign init_acc  = bus.op_valid && bus.op_ready && state == INIT;
  // Retires of init ops are never counted, so they are ignored while initialising.
  assign ret       = bus.op_retire && state != INIT;
  assign ret_ok    = ret && inflight != '0;
  assign evict     = ret_ok && bus.op_evict;
  assign ack_ok    = bus.wb_ack && pending_wb != '0;
  vx_flush_walker #(.LINES(LINES), .NUM_WAYS(NUM_WAYS), .LSEL_W(LSEL_W)) u_walker (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .advance  (init_acc || issue),
    .single   (state == INIT),
    .line_cnt (line_cnt),
    .way_oh   (way_oh),
    .last     (last)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      INIT:    state_n = (init_acc && last) ? IDLE : INIT;
      IDLE:    state_n = bus.flush_req_valid ? FLUSH : IDLE;
      FLUSH:   state_n = (issue && last) ? DRAIN : FLUSH;
      DRAIN:   state_n = (inflight == '0 && pending_wb == '0) ? DONE : DRAIN;
      DONE:    state_n = bus.flush_rsp_ready ? IDLE : DONE;
      default: state_n = INIT;
    endcase
  end
  always_comb begin
    bus.op_valid        = !reset && (state == INIT || (state == FLUSH && occupancy < (CNT_W+1)'(MAX_PENDING)));
    bus.op_init         = state == INIT;
    bus.op_flush        = state == FLUSH;
    bus.op_line_sel     = line_cnt;
    bus.op_way_sel      = (state == INIT) ? '1 : way_oh;
    bus.flush_req_ready = !reset && state == IDLE;
    bus.flush_rsp_valid = !reset && state == DONE;
    init_busy           = reset || state == INIT;
    busy                = reset || state != IDLE;
  end
  // An evicting retire hands its unit from inflight to pending_wb, keeping the sum constant.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight   <= '0;
      pending_wb <= '0;
    end else begin
      inflight   <= inflight + CNT_W'(issue) - CNT_W'(ret_ok);
      pending_wb <= pending_wb + CNT_W'(evict) - CNT_W'(ack_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(ret && inflight == '0));
      assert (!(bus.wb_ack && pending_wb == '0));
    end
  end
`ifdef VX_CACHE_FLUSH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_flush_cnt <= '0;
      perf_dirty_cnt <= '0;
    end else begin
      perf_flush_cnt <= perf_flush_cnt + 32'(state == DONE && bus.flush_rsp_ready);
      perf_dirty_cnt <= perf_dirty_cnt + 32'(evict && (state == FLUSH || state == DRAIN));
    end
  end
`endif
endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
// tb_vx_cache_flush_ctrl: directed checks on two instances (MAX_PENDING 4 and 2), 4 lines x 2 ways.
module tb_vx_cache_flush_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic a_busy, a_init_busy, b_busy, b_init_busy;
  logic [1:0] iss_d = 2'b00;
  int errors = 0;
  int checks = 0;
  int ib, pb, nret, nack, niss;
`ifdef VX_CACHE_FLUSH_PERF_EN
  logic [31:0] a_perf_flush, a_perf_dirty, b_perf_flush, b_perf_dirty;
`endif
  always #5 clk = ~clk;
  vx_cache_flush_if #(.LSEL_W(2), .NUM_WAYS(2)) a ();
  vx_cache_flush_if #(.LSEL_W(2), .NUM_WAYS(2)) b ();
  vx_cache_flush_ctrl #(.CACHE_SIZE(128), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(2), .MAX_PENDING(4)) dut_a (
    .clk(clk), .reset(reset), .bus(a), .init_busy(a_init_busy), .busy(a_busy)
`ifdef VX_CACHE_FLUSH_PERF_EN
    , .perf_flush_cnt(a_perf_flush), .perf_dirty_cnt(a_perf_dirty)
`endif
  );
  vx_cache_flush_ctrl #(.CACHE_SIZE(128), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(2), .MAX_PENDING(2)) dut_b (
    .clk(clk), .reset(reset), .bus(b), .init_busy(b_init_busy), .busy(b_busy)
`ifdef VX_CACHE_FLUSH_PERF_EN
    , .perf_flush_cnt(b_perf_flush), .perf_dirty_cnt(b_perf_dirty)
`endif
  );
  // Instance A: every accepted flush op retires (clean) two cycles after it is accepted.
  always @(posedge clk) iss_d <= {iss_d[0], a.op_valid && a.op_ready && a.op_flush};
  assign a.op_retire = iss_d[1];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic init_walk();
    for (int k = 0; k < 4; k++) begin
      chk("init_op", {a.op_valid, a.op_init, a.op_flush, a.op_line_sel, a.op_way_sel}, {3'b110, 2'(k), 2'b11});
      @(negedge clk); #1;
    end
    chk("init_done", {a.flush_req_ready, a_busy, a_init_busy, a.flush_rsp_valid}, 4'b1000);
  endtask
  task automatic a_flush(input bit toggle, input int n);
    int got = 0;
    int cyc = 0;
    bit held = 0;
    logic [3:0] held_op = '0;
    logic [5:0] e;
    a.flush_req_valid = 1'b1;
    chk("a_req_ready", a.flush_req_ready, 1);
    while (got < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      a.flush_req_valid = 1'b0;
      a.op_ready = toggle ? cyc[0] : 1'b1;
      #1;
      if (held) chk("a_hold", {a.op_valid, a.op_line_sel, a.op_way_sel}, {1'b1, held_op});
      held = a.op_valid && !a.op_ready;
      held_op = {a.op_line_sel, a.op_way_sel};
      if (a.op_valid && a.op_ready) begin
        e = {2'b10, 2'(got / 2), (got % 2 == 1) ? 2'b10 : 2'b01};
        chk("a_op", {a.op_flush, a.op_init, a.op_line_sel, a.op_way_sel}, e);
        got++;
      end
    end
    a.op_ready = 1'b1;
    chk("a_op_count", got, n);
    if (n == 8) begin
      if (!toggle) begin
        @(negedge clk); #1;
        chk("a_drain", {a.op_valid, a.flush_rsp_valid, a_busy}, 3'b001);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("a_rsp_early", a.flush_rsp_valid, 0);
        @(negedge clk); #1;
      end else begin
        for (int c = 0; c < 20 && !a.flush_rsp_valid; c++) begin
          @(negedge clk); #1;
        end
      end
      chk("a_rsp", a.flush_rsp_valid, 1);
      a.flush_rsp_ready = 1'b1;
      @(negedge clk);
      a.flush_rsp_ready = 1'b0;
      #1;
      chk("a_idle", {a_busy, a.flush_rsp_valid, a.flush_req_ready}, 3'b001);
    end
  endtask
  task automatic b_run(input int dirty);
    bit done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      b.flush_req_valid = 1'b0;
      b.op_retire = ib > 0;
      b.op_evict = nret < dirty;
      b.wb_ack = pb > 0;
      #1;
      done = b.flush_rsp_valid;
      if (!done) begin
        if (b.op_valid) begin
          chk("b_throttle", ib + pb < 2, 1);
          niss++;
        end
        if (b.op_retire) begin
          ib--;
          nret++;
          if (b.op_evict) pb++;
        end
        if (b.wb_ack) begin
          pb--;
          nack++;
        end
        if (b.op_valid) ib++;
      end
    end
    b.op_retire = 1'b0;
    b.op_evict = 1'b0;
    b.wb_ack = 1'b0;
    chk("b_rsp_seen", done, 1);
    chk("b_ops", niss, 8);
    chk("b_acks", nack, dirty);
    b.flush_rsp_ready = 1'b1;
    @(negedge clk);
    b.flush_rsp_ready = 1'b0;
    #1;
    chk("b_idle", {b_busy, b.flush_rsp_valid}, 2'b00);
  endtask
  initial begin
    reset = 1'b1;
    {a.flush_req_valid, a.flush_rsp_ready, a.op_ready, a.op_evict, a.wb_ack} = '0;
    {b.flush_req_valid, b.flush_rsp_ready, b.op_retire, b.op_evict, b.wb_ack} = '0;
    b.op_ready = 1'b1;
    @(negedge clk); #1;
    chk("a_reset", {a.op_valid, a_busy, a_init_busy, a.flush_req_ready, a.flush_rsp_valid}, 5'b01100);
    chk("b_reset", {b.op_valid, b_busy, b_init_busy, b.flush_req_ready, b.flush_rsp_valid}, 5'b01100);
    reset = 1'b0;
    a.op_ready = 1'b1;
    #1;
    init_walk();
    a_flush(1'b0, 8);
    a_flush(1'b0, 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("a_midreset", {a.op_valid, a_busy, a_init_busy, a.flush_rsp_valid}, 4'b0110);
    @(negedge clk);
    reset = 1'b0;
    #1;
    init_walk();
    a_flush(1'b1, 8);
    b.flush_req_valid = 1'b1;
    chk("b_req_ready", b.flush_req_ready, 1);
    @(negedge clk);
    b.flush_req_valid = 1'b0;
    #1;
    chk("b_op0", {b.op_valid, b.op_line_sel, b.op_way_sel}, 5'b10001);
    @(negedge clk); #1;
    chk("b_op1", {b.op_valid, b.op_line_sel, b.op_way_sel}, 5'b10010);
    @(negedge clk); #1;
    chk("b_full", b.op_valid, 0);
    b.op_retire = 1'b1;
    b.op_evict = 1'b1;
    @(negedge clk); #1;
    chk("b_full_ret1", b.op_valid, 0);
    @(negedge clk);
    b.op_retire = 1'b0;
    #1;
    chk("b_full_wb2", b.op_valid, 0);
    b.wb_ack = 1'b1;
    @(negedge clk);
    b.wb_ack = 1'b0;
    #1;
    chk("b_op2", {b.op_valid, b.op_line_sel, b.op_way_sel}, 5'b10101);
    @(negedge clk); #1;
    chk("b_one_more", b.op_valid, 0);
    ib = 1; pb = 1; nret = 2; nack = 1; niss = 3;
    b_run(8);
`ifdef VX_CACHE_FLUSH_PERF_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("perf_reset", {b_perf_flush, b_perf_dirty} == 64'd0, 1);
    for (int f = 0; f < 2; f++) begin
      ib = 0; pb = 0; nret = 0; nack = 0; niss = 0;
      b.flush_req_valid = 1'b1;
      b_run(3);
    end
    chk("perf_flush_cnt", b_perf_flush, 2);
    chk("perf_dirty_cnt", b_perf_dirty, 6);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
